and_gate_monitor: RTL and testbench
===================================

# and_gate_monitor

Synchronous self-checking monitor for the two-input AND datapath. It samples the stimulus pair (a, b) and the DUT response q once per clock over a fixed window and checks q against a & b. It reports pass/fail, error and check counts, and the first failing vector. It sits on the observing end of the a/b/q interface, in the bench or on-chip BIST wrapper, opposite the stimulus driver.

## Interface
- SAMPLE_N, default 16: number of clock cycles checked per run; legal range 1..2**CNT_W-1.
- CNT_W, default 8: width of the check and error counters.

- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- start  in  1  one-cycle request to begin a run; honoured in IDLE and DONE only.
- a  in  1  stimulus bit a as driven to the DUT.
- b  in  1  stimulus bit b as driven to the DUT.
- q  in  1  DUT output under check.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE; held until start or reset.
- pass  out  1  valid when done=1; 1 iff err_cnt==0 (plus the coverage condition when enabled).
- chk_cnt  out  CNT_W  samples checked in the current or last run.
- err_cnt  out  CNT_W  mismatches in the current or last run; saturates at all-ones.
- first_err_vec  out  3  {a,b,q} of the first mismatch; 0 if none.
- first_err_idx  out  CNT_W  chk_cnt value at the first mismatch; 0 if none.
- cov  out  4  one bit per {a,b} combination seen (bit index = {a,b}); 0 when the coverage feature is compiled out.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, start=1: go to RUN. Clear chk_cnt, err_cnt, first_err_*, cov and pass.
- RUN: every cycle, sample a, b and q, then:
  - chk_cnt += 1.
  - If q != (a & b): err_cnt += 1, saturating.
  - On the first mismatch of the run only, latch first_err_vec={a,b,q} and first_err_idx=chk_cnt (the pre-increment value).
  - When the sample taken is the SAMPLE_N-th (chk_cnt==SAMPLE_N-1 before the increment), go to DONE.
- DONE: outputs frozen. start=1 re-enters RUN with the same clears as from IDLE.
- start while in RUN: ignored. A run is not restartable.
- Inputs a, b and q are sampled only in RUN. X or Z on q counts as a mismatch in simulation.
- err_cnt saturation: once at 2**CNT_W-1 it holds, and pass stays 0.

## Timing
- Reset values: busy=0, done=0, pass=0, chk_cnt=0, err_cnt=0, first_err_vec=0, first_err_idx=0, cov=0.
- start sampled high at edge N:
  - busy=1 after edge N.
  - First sample taken at edge N+1.
  - The last (SAMPLE_N-th) sample is taken at edge N+SAMPLE_N.
  - At that same edge, busy=0 and done=1. pass is valid from then on.
- Counters and first-error fields are registered and reflect each sample one edge after it is taken. There is no combinational path from inputs to outputs.
- Reset asserted at any edge, including mid-RUN: takes priority over start; all outputs return to reset values at that edge and the run is discarded.
- reset and start high together: reset wins; the FSM is in IDLE afterwards.
- SAMPLE_N=1: RUN lasts exactly one cycle.

## Configuration
- MON_COV_EN defined:
  - cov[{a,b}] is set on each RUN sample.
  - pass = (err_cnt==0) && (cov==4'b1111).
- MON_COV_EN undefined:
  - cov is tied to 4'b0000.
  - pass = (err_cnt==0).
  - No coverage flops are synthesised.

## Test plan
- Correct AND DUT, SAMPLE_N=16, stimulus cycles (0,0),(0,1),(1,0),(1,1): done after 16 cycles with chk_cnt=16, err_cnt=0, pass=1, and cov=4'b1111 when MON_COV_EN is defined.
- q forced to a|b, same stimulus: err_cnt=8, pass=0, first_err_vec=3'b011, first_err_idx=1.
- With a=b=1 held and a correct DUT: MON_COV_EN defined gives pass=0 and cov=4'b1000; MON_COV_EN undefined gives pass=1.
- reset pulsed at RUN cycle 5: next edge shows busy=0, done=0, chk_cnt=0. A later start runs a full 16 samples.
- start pulsed again during RUN at cycle 3: no effect, done still at edge N+16. start in DONE clears results and runs again.
- CNT_W=4, SAMPLE_N=15, q stuck at 1: err_cnt reaches 15 and holds there, pass=0.

Source files
------------

// File: rtl/and_gate_monitor_if.sv
// Observation bundle between a stimulus driver (master) and the AND-datapath monitor (slave).
// The master drives start/a/b/q; the monitor returns status, counters and first-error capture.
interface and_gate_monitor_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             a;
  logic             b;
  logic             q;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] chk_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [2:0]       first_err_vec;
  logic [CNT_W-1:0] first_err_idx;
  logic [3:0]       cov;

  modport master (
    output start, a, b, q,
    input  busy, done, pass, chk_cnt, err_cnt, first_err_vec, first_err_idx, cov
  );

  modport slave (
    input  start, a, b, q,
    output busy, done, pass, chk_cnt, err_cnt, first_err_vec, first_err_idx, cov
  );
endinterface

// File: rtl/and_gate_monitor.sv
// Checks q against a & b for SAMPLE_N cycles per run; reports pass, counts and first failing vector.
// Define MON_COV_EN to track {a,b} coverage and require full coverage for pass.
module and_gate_monitor #(
  parameter int SAMPLE_N = 16,
  parameter int CNT_W    = 8
) (
  input logic               clk,
  input logic               reset,
  and_gate_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLE_N - 1);
  localparam logic [CNT_W-1:0] SAT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [2:0]       fvec_q, fvec_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;
  logic             mismatch;
  logic             cov_ok;

  // Case inequality so an X or Z on q is flagged in simulation.
  assign mismatch = (mon.q !== (mon.a & mon.b));

`ifdef MON_COV_EN
  logic [3:0] cov_q, cov_d;
  assign cov_ok  = (cov_q == 4'b1111);
  assign mon.cov = cov_q;
`else
  assign cov_ok  = 1'b1;
  assign mon.cov = 4'b0000;
`endif

  always_comb begin
    state_d = state_q;
    chk_d   = chk_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fidx_d  = fidx_q;
`ifdef MON_COV_EN
    cov_d   = cov_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (mon.start) begin
          state_d = RUN;
          chk_d   = '0;
          err_d   = '0;
          fvec_d  = '0;
          fidx_d  = '0;
`ifdef MON_COV_EN
          cov_d   = '0;
`endif
        end
      end
      RUN: begin
        chk_d = chk_q + 1'b1;
        if (mismatch) begin
          if (err_q != SAT_MAX) err_d = err_q + 1'b1;
          // err_q only leaves zero on a mismatch and never wraps, so zero marks the first one.
          if (err_q == '0) begin
            fvec_d = {mon.a, mon.b, mon.q};
            fidx_d = chk_q;
          end
        end
`ifdef MON_COV_EN
        cov_d = cov_q | (4'b0001 << {mon.a, mon.b});
`endif
        if (chk_q == LAST_IDX) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      chk_q   <= '0;
      err_q   <= '0;
      fvec_q  <= '0;
      fidx_q  <= '0;
`ifdef MON_COV_EN
      cov_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fidx_q  <= fidx_d;
`ifdef MON_COV_EN
      cov_q   <= cov_d;
`endif
    end
  end

  assign mon.busy          = (state_q == RUN);
  assign mon.done          = (state_q == DONE);
  assign mon.pass          = (state_q == DONE) && (err_q == '0) && cov_ok;
  assign mon.chk_cnt       = chk_q;
  assign mon.err_cnt       = err_q;
  assign mon.first_err_vec = fvec_q;
  assign mon.first_err_idx = fidx_q;

endmodule

// File: tb/tb_and_gate_monitor.sv
// Directed/random bench for and_gate_monitor: 16-sample 8-bit instance plus a 15-sample 4-bit saturation instance.
module tb_and_gate_monitor;
  localparam int SN  = 16;
  localparam int SN2 = 15;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  and_gate_monitor_if #(.CNT_W(8)) if1 ();
  and_gate_monitor_if #(.CNT_W(4)) if2 ();

  and_gate_monitor #(.SAMPLE_N(SN),  .CNT_W(8)) dut1 (.clk(clk), .reset(reset), .mon(if1));
  and_gate_monitor #(.SAMPLE_N(SN2), .CNT_W(4)) dut2 (.clk(clk), .reset(reset), .mon(if2));

`ifdef MON_COV_EN
  localparam bit COV_ON = 1'b1;
`else
  localparam bit COV_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: cycling (0,0),(0,1),(1,0),(1,1) correct; 1: same with q=a|b; 2: a=b=1 correct; 3: random with injected errors
  task automatic do_run(input int mode, input int restart_at, input string tag);
    logic       sa[SN];
    logic       sb[SN];
    logic       sq[SN];
    int         e_exp;
    int         fi_exp;
    logic [2:0] fv_exp;
    logic [3:0] cv;
    logic       pass_exp;
    @(negedge clk);
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    check({tag, ".busy_start"}, 32'(if1.busy), 1);
    check({tag, ".chk_cleared"}, 32'(if1.chk_cnt), 0);
    check({tag, ".err_cleared"}, 32'(if1.err_cnt), 0);
    check({tag, ".done_cleared"}, 32'(if1.done), 0);
    for (int i = 0; i < SN; i++) begin
      logic [1:0] pat;
      pat = 2'(i);
      case (mode)
        0: begin sa[i] = pat[1]; sb[i] = pat[0]; sq[i] = pat[1] & pat[0]; end
        1: begin sa[i] = pat[1]; sb[i] = pat[0]; sq[i] = pat[1] | pat[0]; end
        2: begin sa[i] = 1'b1;   sb[i] = 1'b1;   sq[i] = 1'b1; end
        default: begin
          sa[i] = 1'($urandom_range(0, 1));
          sb[i] = 1'($urandom_range(0, 1));
          sq[i] = ($urandom_range(0, 3) == 0) ? ~(sa[i] & sb[i]) : (sa[i] & sb[i]);
        end
      endcase
      if1.a = sa[i];
      if1.b = sb[i];
      if1.q = sq[i];
      if1.start = (i == restart_at);
      @(negedge clk);
      if1.start = 1'b0;
      if (i < SN - 1) begin
        check({tag, ".busy_run"}, 32'(if1.busy), 1);
        check({tag, ".chk_run"}, 32'(if1.chk_cnt), 32'(i + 1));
      end
    end
    e_exp = 0; fi_exp = 0; fv_exp = 3'b000; cv = 4'b0000;
    for (int k = 0; k < SN; k++) begin
      if (sq[k] != (sa[k] & sb[k])) begin
        if (e_exp == 0) begin
          fv_exp = {sa[k], sb[k], sq[k]};
          fi_exp = k;
        end
        if (e_exp < 255) e_exp++;
      end
      cv[{sa[k], sb[k]}] = 1'b1;
    end
    pass_exp = (e_exp == 0) && (!COV_ON || cv == 4'b1111);
    check({tag, ".done"}, 32'(if1.done), 1);
    check({tag, ".busy_end"}, 32'(if1.busy), 0);
    check({tag, ".chk_end"}, 32'(if1.chk_cnt), SN);
    check({tag, ".err_end"}, 32'(if1.err_cnt), 32'(e_exp));
    check({tag, ".first_vec"}, 32'(if1.first_err_vec), 32'(fv_exp));
    check({tag, ".first_idx"}, 32'(if1.first_err_idx), 32'(fi_exp));
    check({tag, ".pass"}, 32'(if1.pass), 32'(pass_exp));
    check({tag, ".cov"}, 32'(if1.cov), COV_ON ? 32'(cv) : 0);
    @(negedge clk);
    check({tag, ".done_hold"}, 32'(if1.done), 1);
    check({tag, ".chk_hold"}, 32'(if1.chk_cnt), SN);
  endtask

  initial begin
    reset = 1'b1;
    if1.start = 1'b0; if1.a = 1'b0; if1.b = 1'b0; if1.q = 1'b0;
    if2.start = 1'b0; if2.a = 1'b0; if2.b = 1'b0; if2.q = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(if1.busy), 0);
    check("rst.done", 32'(if1.done), 0);
    check("rst.pass", 32'(if1.pass), 0);
    check("rst.chk", 32'(if1.chk_cnt), 0);
    check("rst.err", 32'(if1.err_cnt), 0);
    check("rst.fvec", 32'(if1.first_err_vec), 0);
    check("rst.fidx", 32'(if1.first_err_idx), 0);
    check("rst.cov", 32'(if1.cov), 0);
    check("rst2.err", 32'(if2.err_cnt), 0);
    reset = 1'b0;

    do_run(0, -1, "good");
    do_run(1, -1, "or_dut");
    check("or_dut.err_const", 32'(if1.err_cnt), 8);
    check("or_dut.fvec_const", 32'(if1.first_err_vec), 32'b011);
    check("or_dut.fidx_const", 32'(if1.first_err_idx), 1);
    do_run(2, -1, "a1b1");
    check("a1b1.pass_const", 32'(if1.pass), COV_ON ? 0 : 1);
    do_run(0, 3, "restart_ignored");
    do_run(0, -1, "start_in_done");
    for (int r = 0; r < 4; r++) do_run(3, -1, "random");

    // Reset in the middle of a run discards it.
    @(negedge clk);
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    if1.a = 1'b1; if1.b = 1'b0; if1.q = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst.busy", 32'(if1.busy), 0);
    check("midrst.done", 32'(if1.done), 0);
    check("midrst.chk", 32'(if1.chk_cnt), 0);
    check("midrst.err", 32'(if1.err_cnt), 0);
    check("midrst.fvec", 32'(if1.first_err_vec), 0);
    do_run(0, -1, "after_rst");

    // Reset wins over a simultaneous start.
    @(negedge clk);
    reset = 1'b1; if1.start = 1'b1;
    @(negedge clk);
    reset = 1'b0; if1.start = 1'b0;
    check("rst_start.busy", 32'(if1.busy), 0);
    check("rst_start.done", 32'(if1.done), 0);
    @(negedge clk);
    check("rst_start.idle_busy", 32'(if1.busy), 0);
    check("rst_start.idle_chk", 32'(if1.chk_cnt), 0);

    // Narrow counter: every sample mismatches, err_cnt tops out at all-ones.
    if2.a = 1'b0; if2.b = 1'b0; if2.q = 1'b1;
    if2.start = 1'b1;
    @(negedge clk);
    if2.start = 1'b0;
    check("sat.busy", 32'(if2.busy), 1);
    repeat (SN2) @(negedge clk);
    check("sat.done", 32'(if2.done), 1);
    check("sat.chk", 32'(if2.chk_cnt), SN2);
    check("sat.err", 32'(if2.err_cnt), 15);
    check("sat.pass", 32'(if2.pass), 0);
    check("sat.fvec", 32'(if2.first_err_vec), 32'b001);
    check("sat.fidx", 32'(if2.first_err_idx), 0);
    repeat (3) @(negedge clk);
    check("sat.err_hold", 32'(if2.err_cnt), 15);
    check("sat.done_hold", 32'(if2.done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
